// File: rtl/obi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : obi_pkg
// Brief   : Shared OBI widths, response struct, grant-FSM encoding, clog2.
// Revision: 1.0 - initial release
// ============================================================================
package obi_pkg;

    localparam int OBI_AW  = 32;
    localparam int OBI_DW  = 32;
    localparam int OBI_BEW = 4;

    typedef struct packed {
        logic              err;
        logic [OBI_DW-1:0] rdata;
    } obi_rsp_t;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    function automatic int unsigned obi_clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                v = v >> 1;
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/obi_reg_secondary_if.sv
`default_nettype none
// ============================================================================
// Module  : obi_reg_secondary_if
// Brief   : OBI request/response bundle with primary and secondary views.
// Revision: 1.0 - initial release
// ============================================================================
interface obi_reg_secondary_if import obi_pkg::*; ();

    logic                req;
    logic                gnt;
    logic [OBI_AW-1:0]   addr;
    logic                we;
    logic [OBI_BEW-1:0]  be;
    logic [OBI_DW-1:0]   wdata;
    logic                rvalid;
    logic                rready;
    logic [OBI_DW-1:0]   rdata;
    logic                err;

    modport master (
        output req, addr, we, be, wdata, rready,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata, rready,
        output gnt, rvalid, rdata, err
    );

endinterface
`default_nettype wire

// File: rtl/obi_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : obi_rsp_fifo
// Brief   : Synchronous FIFO, wrap-around pointers plus occupancy counter.
// Revision: 1.0 - initial release
// ============================================================================
module obi_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] c_PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == c_DEPTH);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == c_PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == c_PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only consumed while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/obi_reg_secondary.sv
`default_nettype none
// ============================================================================
// Module  : obi_reg_secondary
// Brief   : OBI responder with a byte-writable register file and queued responses.
// Revision: 1.0 - initial release
// ============================================================================
module obi_reg_secondary import obi_pkg::*; #(
    parameter int NUM_REGS  = 16,
    parameter int GNT_WAIT  = 0,
    parameter int RSP_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    obi_reg_secondary_if.slave   bus
);

    localparam int AW  = int'(obi_clog2(NUM_REGS));
    localparam int CW  = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
    localparam int RW  = $bits(obi_rsp_t);
    localparam logic [CW-1:0]     c_WAIT       = CW'(GNT_WAIT);
    localparam logic [OBI_AW-1:0] c_ADDR_LIMIT = OBI_AW'(NUM_REGS * 4);

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [OBI_DW-1:0] regs_q [NUM_REGS];

    logic              gnt;
    logic              fire;
    logic              in_range;
    logic [AW-1:0]     idx;
    obi_rsp_t          rsp_push;
    obi_rsp_t          rsp_head;
    logic [RW-1:0]     fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    assign in_range = (bus.addr < c_ADDR_LIMIT);
    assign idx      = bus.addr[AW+1:2];
    assign fire     = bus.req & gnt;

    // ---------------- grant FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- grant FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.req && (GNT_WAIT != 0)) begin
                    state_d = c_ST_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            c_ST_WAIT: begin
                // A dropped request abandons the wait without any side effects.
                if (!bus.req || gnt) begin
                    state_d = c_ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q < c_WAIT) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = c_ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- grant FSM: outputs ----------------
    // Grant looks only at "full", never at a same-cycle pop, keeping rready off this path.
    always_comb begin
        gnt = 1'b0;
        case (state_q)
            c_ST_IDLE: gnt = (GNT_WAIT == 0) && bus.req && !fifo_full;
            c_ST_WAIT: gnt = (cnt_q >= c_WAIT) && bus.req && !fifo_full;
            default:   gnt = 1'b0;
        endcase
    end

    // ---------------- register file ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (fire && bus.we && in_range) begin
            for (int b = 0; b < OBI_BEW; b++) begin
                if (bus.be[b]) begin
                    regs_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // Reads capture the pre-write register value of the grant cycle.
    always_comb begin
        rsp_push = '0;
        if (!in_range) begin
            rsp_push.err = 1'b1;
        end else if (!bus.we) begin
            rsp_push.rdata = regs_q[idx];
        end
    end

    // ---------------- response queue ----------------
    obi_rsp_fifo #(
        .WIDTH (RW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fire),
        .pop_i   (fifo_pop),
        .data_i  (rsp_push),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign rsp_head   = fifo_head;
    assign fifo_pop   = ~fifo_empty & bus.rready;

    assign bus.gnt    = gnt;
    assign bus.rvalid = ~fifo_empty;
    assign bus.rdata  = fifo_empty ? '0 : rsp_head.rdata;
    assign bus.err    = ~fifo_empty & rsp_head.err;

endmodule
`default_nettype wire
